// File: rtl/tb_mem_pkg.sv
// ---------------------------------------------------------------------------
// tb_mem_pkg
// Shared types for the data-port memory responder used in the core bench.
//   stall_mode_e  : encoding of the stall_mode_i control (3 behaves as 2)
//   resp_entry_t  : one accepted-but-unanswered request in the response FIFO
//   merge_bytes   : byte-enable merge of a write into an existing word
// ---------------------------------------------------------------------------
package tb_mem_pkg;

    typedef enum logic [1:0] {
        STALL_NONE       = 2'd0,
        STALL_GNT        = 2'd1,
        STALL_GNT_RVALID = 2'd2
    } stall_mode_e;

    typedef struct packed {
        logic        we;
        logic [31:0] data;
        logic [2:0]  age;
    } resp_entry_t;

    localparam logic [2:0] AGE_SAT = 3'd7;

    // Replaces only the bytes whose enable bit is set; other bytes keep
    // their previous contents.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/tb_mem_lfsr.sv
// ---------------------------------------------------------------------------
// tb_mem_lfsr
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to generate pseudo-random
// grant and response stalls.
//   clk_i   in  1   clock
//   rst_ni  in  1   async reset, active low (loads SEED)
//   en_i    in  1   advance one step per cycle when high
//   lfsr_o  out 16  current LFSR state
// ---------------------------------------------------------------------------
module tb_mem_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    logic feedback;

    // Right-shifting form: bit 0 is tap 16, bits 2,3,5 are taps 14,13,11.
    // The new bit enters at the top.
    assign feedback = lfsr_o[0] ^ lfsr_o[2] ^ lfsr_o[3] ^ lfsr_o[5];

    // State register; returns to the seed on every reset so stall patterns
    // are reproducible run to run.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_o <= SEED;
        end else if (en_i) begin
            lfsr_o <= {feedback, lfsr_o[15:1]};
        end
    end

endmodule

// File: rtl/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Memory-side responder for the core's data port (req/gnt/rvalid). Models a
// word-organised SRAM with a minimum response latency, a bounded number of
// outstanding requests and optional LFSR-driven grant/response stalls.
//   clk_i          in  1   clock
//   rst_ni         in  1   async reset, active low
//   stall_mode_i   in  2   0 none, 1 gnt stall, 2/3 gnt+rvalid stall
//   data_req_i     in  1   request valid from core
//   data_gnt_o     out 1   grant (combinational)
//   data_we_i      in  1   1 write, 0 read
//   data_be_i      in  4   byte enables
//   data_addr_i    in  32  byte address
//   data_wdata_i   in  32  write data
//   data_rvalid_o  out 1   response valid (registered)
//   data_rdata_o   out 32  read data (registered, 0 for writes)
// ---------------------------------------------------------------------------
module tb_data_mem_responder
    import tb_mem_pkg::*;
#(
    parameter int          MEM_WORDS    = 16384,
    parameter int          RESP_LATENCY = 1,
    parameter int          OUTSTANDING  = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  stall_mode_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);

    logic [15:0]      lfsr;
    logic             gstall;
    logic             rstall;
    logic [31:0]      mem [MEM_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      mem_word;
    resp_entry_t      fifo [OUTSTANDING];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    resp_entry_t      head;
    resp_entry_t      incoming;
    logic             handshake;
    logic             fifo_empty;
    logic             head_due;
    logic             bypass;
    logic             issue;
    logic             push;
    logic             pop;
    logic [31:0]      resp_data;
    logic             unused_ok;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    tb_mem_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (1'b1),
        .lfsr_o (lfsr)
    );

    assign gstall = (stall_mode_i != STALL_NONE) & lfsr[0];
    assign rstall = (stall_mode_i >= STALL_GNT_RVALID) & lfsr[1];

    // Occupancy is the registered count, so a pop in the same cycle does
    // not open a slot for the current request.
    assign data_gnt_o = data_req_i & ~gstall & (count < CNT_MAX) & rst_ni;
    assign handshake  = data_req_i & data_gnt_o;

    assign word_idx = data_addr_i[2 +: IDX_W];
    assign mem_word = mem[word_idx];

    assign fifo_empty = (count == '0);
    assign head       = fifo[rd_ptr];

    // Build the response entry for the current handshake and decide whether
    // the oldest pending entry answers next cycle. With an empty FIFO and a
    // latency of one, the incoming request itself is the oldest entry and is
    // answered without ever being stored.
    always_comb begin
        incoming      = '0;
        incoming.we   = data_we_i;
        incoming.data = data_we_i ? 32'd0 : mem_word;
        incoming.age  = 3'd1;
        head_due  = ~fifo_empty & ((int'(head.age) + 1) >= RESP_LATENCY);
        bypass    = fifo_empty & handshake & (RESP_LATENCY == 1);
        issue     = (head_due | bypass) & ~rstall;
        pop       = issue & ~fifo_empty;
        push      = handshake & ~(issue & fifo_empty);
        resp_data = fifo_empty ? incoming.data : head.data;
    end

    // Response FIFO, per-entry age counters and the registered response
    // outputs. Every entry ages each cycle (saturating); a freshly pushed
    // entry overrides that with age 1, since in the cycle after acceptance
    // one edge has passed. Reset empties the FIFO, dropping pending replies.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                fifo[i] <= '0;
            end
        end else begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (fifo[i].age != AGE_SAT) begin
                    fifo[i].age <= fifo[i].age + 3'd1;
                end
            end
            if (push) begin
                fifo[wr_ptr] <= incoming;
                wr_ptr       <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            data_rvalid_o <= issue;
            if (issue) begin
                data_rdata_o <= resp_data;
            end
        end
    end

    // Memory array: deliberately not reset so contents survive rst_ni.
    // Read data for a response was already captured from the pre-write
    // word above, so the write here cannot disturb it.
    always_ff @(posedge clk_i) begin
        if (handshake && data_we_i) begin
            mem[word_idx] <= merge_bytes(mem_word, data_wdata_i, data_be_i);
        end
    end

    assign unused_ok = ^{data_addr_i[31:IDX_W+2], data_addr_i[1:0], lfsr[15:2], head.we};

    // The core must keep the request payload stable while it waits for a
    // grant; the responder itself does not rely on this.
    property p_payload_stable;
        @(posedge clk_i) disable iff (!rst_ni)
        (data_req_i && !data_gnt_o) |=> $stable({data_we_i, data_be_i, data_addr_i, data_wdata_i});
    endproperty
    a_payload_stable: assert property (p_payload_stable);

endmodule

// File: tb/tb_tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_tb_data_mem_responder
// Scoreboard bench for tb_data_mem_responder. Two instances: dut_a with
// latency 1 and dut_b with latency 3, both with two outstanding slots.
// Each accepted request pushes its expected response, computed from a plain
// word-array model, into a per-instance queue; a monitor per instance pops
// and compares whenever rvalid is seen.
// ---------------------------------------------------------------------------
module tb_tb_data_mem_responder;

    localparam int MEM_WORDS = 16384;
    localparam int LAT_A     = 1;
    localparam int LAT_B     = 3;
    localparam int OUT_N     = 2;

    typedef struct {
        logic [31:0] data;
        int          t_acc;
        int          exact;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  stall_a, stall_b;
    logic        req_a, gnt_a, we_a, rvalid_a;
    logic        req_b, gnt_b, we_b, rvalid_b;
    logic [3:0]  be_a, be_b;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [31:0] addr_b, wdata_b, rdata_b;

    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        mon_a, mon_b;
    logic [31:0] model_a [int];
    logic [31:0] model_b [int];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    always #5 clk = ~clk;

    // Cycle number; stable between rising edges, so negedge samples see
    // the number of the cycle they belong to.
    always @(posedge clk) cyc <= cyc + 1;

    tb_data_mem_responder #(
        .MEM_WORDS(MEM_WORDS), .RESP_LATENCY(LAT_A), .OUTSTANDING(OUT_N), .LFSR_SEED(16'hACE1)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .stall_mode_i(stall_a),
        .data_req_i(req_a), .data_gnt_o(gnt_a), .data_we_i(we_a), .data_be_i(be_a),
        .data_addr_i(addr_a), .data_wdata_i(wdata_a),
        .data_rvalid_o(rvalid_a), .data_rdata_o(rdata_a)
    );

    tb_data_mem_responder #(
        .MEM_WORDS(MEM_WORDS), .RESP_LATENCY(LAT_B), .OUTSTANDING(OUT_N), .LFSR_SEED(16'h1D0F)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .stall_mode_i(stall_b),
        .data_req_i(req_b), .data_gnt_o(gnt_b), .data_we_i(we_b), .data_be_i(be_b),
        .data_addr_i(addr_b), .data_wdata_i(wdata_b),
        .data_rvalid_o(rvalid_b), .data_rdata_o(rdata_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor for dut_a: every rvalid must match the oldest expected reply.
    always @(negedge clk) begin
        if (rvalid_a === 1'b1) begin
            if (q_a.size() == 0) begin
                checkOutput("orphan_rvalid_a", 32'd1, 32'd0);
            end else begin
                mon_a = q_a.pop_front();
                checkOutput("rdata_a", rdata_a, mon_a.data);
                if (mon_a.exact >= 0) checkOutput("rvalid_cycle_a", 32'(cyc), 32'(mon_a.exact));
                else checkOutput("min_latency_a", 32'(cyc >= mon_a.t_acc + LAT_A), 32'd1);
            end
        end
    end

    // Monitor for dut_b, same rules with its own latency.
    always @(negedge clk) begin
        if (rvalid_b === 1'b1) begin
            if (q_b.size() == 0) begin
                checkOutput("orphan_rvalid_b", 32'd1, 32'd0);
            end else begin
                mon_b = q_b.pop_front();
                checkOutput("rdata_b", rdata_b, mon_b.data);
                if (mon_b.exact >= 0) checkOutput("rvalid_cycle_b", 32'(cyc), 32'(mon_b.exact));
                else checkOutput("min_latency_b", 32'(cyc >= mon_b.t_acc + LAT_B), 32'd1);
            end
        end
    end

    task automatic drive(input int sel, input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel == 0) begin
            req_a = req; we_a = we; be_a = be; addr_a = addr; wdata_a = wdata;
        end else begin
            req_b = req; we_b = we; be_b = be; addr_b = addr; wdata_b = wdata;
        end
    endtask

    // Issues one request (called just after a rising edge), holds it until
    // granted, then updates the model and queues the expected reply.
    // exp_lat >= 0 demands the reply exactly that many cycles after accept.
    task automatic applyStimulus(input int sel, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int exp_lat, output int t_acc);
        int          waited;
        int          idx;
        logic [31:0] old_word, mask;
        exp_t        e;
        waited = 0;
        t_acc  = -1;
        drive(sel, 1'b1, we, be, addr, wdata);
        while (t_acc < 0 && waited <= 200) begin
            @(negedge clk);
            if ((sel == 0 ? gnt_a : gnt_b) === 1'b1) begin
                t_acc = cyc;
            end else begin
                waited++;
                @(posedge clk);
                #1;
            end
        end
        if (t_acc < 0) begin
            checkOutput("gnt_timeout", 32'd0, 32'd1);
        end else begin
            idx = int'((addr >> 2) % MEM_WORDS);
            if (sel == 0) old_word = model_a.exists(idx) ? model_a[idx] : 32'd0;
            else          old_word = model_b.exists(idx) ? model_b[idx] : 32'd0;
            if (we) begin
                mask = 32'd0;
                for (int k = 0; k < 4; k++) if (be[k]) mask = mask | (32'hFF << (8 * k));
                if (sel == 0) model_a[idx] = (old_word & ~mask) | (wdata & mask);
                else          model_b[idx] = (old_word & ~mask) | (wdata & mask);
                e.data = 32'd0;
            end else begin
                e.data = old_word;
            end
            e.t_acc = t_acc;
            e.exact = (exp_lat >= 0) ? t_acc + exp_lat : -1;
            if (sel == 0) q_a.push_back(e);
            else          q_b.push_back(e);
            @(posedge clk);
            #1;
        end
        if (sel == 0) req_a = 1'b0;
        else          req_b = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(q_a.size() + q_b.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic randomRun(input int sel, input logic [1:0] mode, input int ops);
        int          t, gap, idx;
        logic [31:0] r, addr;
        if (sel == 0) stall_a = mode;
        else          stall_b = mode;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(sel, 1'b1, 4'hF, 32'((64 + i) << 2), $urandom(), -1, t);
        end
        for (int n = 0; n < ops; n++) begin
            r    = $urandom();
            idx  = 64 + $urandom_range(0, 31);
            addr = (r & 32'hFFFF_0000) | (32'(idx) << 2) | (r & 32'h3);
            applyStimulus(sel, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          addr, $urandom(), -1, t);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        waitDrain(sel == 0 ? "drain_random_a" : "drain_random_b");
        stall_a = 2'd0;
        stall_b = 2'd0;
    endtask

    initial begin
        int t_rel, t0, t1, t2, t3, seen;
        rst_n   = 1'b0;
        stall_a = 2'd0;
        stall_b = 2'd0;
        drive(0, 1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Reset holds everything quiet even with a request pending.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_gnt_a", 32'(gnt_a), 32'd0);
        checkOutput("reset_rvalid_a", 32'(rvalid_a), 32'd0);
        checkOutput("reset_rdata_a", rdata_a, 32'd0);
        checkOutput("reset_rvalid_b", 32'(rvalid_b), 32'd0);
        checkOutput("reset_rdata_b", rdata_b, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        t_rel = cyc;

        $display("[TB] write/read, latency 1");
        applyStimulus(0, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, LAT_A, t0);
        checkOutput("first_gnt_cycle", 32'(t0), 32'(t_rel));
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, LAT_A, t1);
        checkOutput("read_gnt_cycle", 32'(t1), 32'(t0 + 1));

        $display("[TB] byte enables");
        applyStimulus(0, 1'b1, 4'hF, 32'h0000_0104, 32'h1122_3344, LAT_A, t0);
        applyStimulus(0, 1'b1, 4'b0101, 32'h0000_0104, 32'hAABB_CCDD, LAT_A, t0);
        applyStimulus(0, 1'b0, 4'h0, 32'h0000_0104, 32'h0, LAT_A, t0);
        waitDrain("drain_be");

        $display("[TB] back-to-back reads");
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, LAT_A, t0);
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_0104, 32'h0, LAT_A, t1);
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, LAT_A, t2);
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_0104, 32'h0, LAT_A, t3);
        checkOutput("b2b_gnt_1", 32'(t1), 32'(t0 + 1));
        checkOutput("b2b_gnt_2", 32'(t2), 32'(t0 + 2));
        checkOutput("b2b_gnt_3", 32'(t3), 32'(t0 + 3));

        $display("[TB] address aliasing");
        applyStimulus(0, 1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, LAT_A, t0);
        applyStimulus(0, 1'b0, 4'hF, 32'h0001_0000, 32'h0, LAT_A, t0);
        waitDrain("drain_alias");

        $display("[TB] backpressure, latency 3");
        applyStimulus(1, 1'b1, 4'hF, 32'h0000_0200, 32'h0102_0304, -1, t0);
        applyStimulus(1, 1'b1, 4'hF, 32'h0000_0204, 32'h5566_7788, -1, t0);
        applyStimulus(1, 1'b1, 4'hF, 32'h0000_0208, 32'h9ABC_DEF0, -1, t0);
        waitDrain("drain_preload_b");
        applyStimulus(1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, LAT_B, t0);
        applyStimulus(1, 1'b0, 4'hF, 32'h0000_0204, 32'h0, LAT_B, t1);
        applyStimulus(1, 1'b0, 4'hF, 32'h0000_0208, 32'h0, LAT_B, t2);
        checkOutput("bp_gnt_2", 32'(t1), 32'(t0 + 1));
        checkOutput("bp_gnt_3", 32'(t2), 32'(t0 + 3));
        waitDrain("drain_bp");

        $display("[TB] reset with pending responses");
        applyStimulus(1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, LAT_B, t0);
        applyStimulus(1, 1'b0, 4'hF, 32'h0000_0204, 32'h0, LAT_B, t1);
        rst_n = 1'b0;
        q_a.delete();
        q_b.delete();
        repeat (2) begin
            @(negedge clk);
            checkOutput("rvalid_in_reset_b", 32'(rvalid_b), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rvalid_b === 1'b1) seen++;
        end
        checkOutput("no_rvalid_after_reset_b", 32'(seen), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] random traffic with stalls");
        randomRun(0, 2'd2, 1000);
        randomRun(1, 2'd3, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

endmodule
